// File: rtl/aes_cfg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the sequential AES SubBytes engine.
package aes_cfg;

    localparam logic [7:0] AFF_C     = 8'h63;
    localparam logic [7:0] INV_AFF_C = 8'h05;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // LSB position of byte k inside a 128-bit state word
    function automatic int byte_lsb(input int k);
        return 8 * k;
    endfunction

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_sbox_byte.sv
// Combinational byte S-box: forward A(inv(x)) or inverse inv(A^-1(x)), selected by dec.
module aes_sbox_byte
    import aes_cfg::*;
(
    input  logic [7:0] x,
    input  logic       dec,
    output logic [7:0] y
);

    logic [7:0] inv_aff;
    logic [7:0] core_in;
    logic [7:0] core_out;
    logic [7:0] fwd_aff;

    // Rotate-right forms of b_(i+k): bit i of {b[k-1:0], b[7:k]} is b[(i+k) mod 8]
    always_comb begin
        inv_aff = {x[1:0], x[7:2]} ^ {x[4:0], x[7:5]} ^ {x[6:0], x[7]} ^ INV_AFF_C;
        core_in = dec ? inv_aff : x;
    end

    gf_mulinv_8 u_inv (
        .a_i   (core_in),
        .inv_o (core_out)
    );

    always_comb begin
        fwd_aff = core_out
                ^ {core_out[3:0], core_out[7:4]}
                ^ {core_out[4:0], core_out[7:5]}
                ^ {core_out[5:0], core_out[7:6]}
                ^ {core_out[6:0], core_out[7]}
                ^ AFF_C;
        y = dec ? core_out : fwd_aff;
    end

endmodule

// File: rtl/gf_mulinv_8.sv
// GF(2^8) multiplicative inverse as a^254 via a fixed square-and-multiply chain; inv(0)=0 falls out.
module gf_mulinv_8
    import aes_cfg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] inv_o
);

    logic [7:0] p2, p3, p6, p12, p15, p30, p60, p120, p240, p252;

    always_comb begin
        p2    = gf_mul(a_i, a_i);
        p3    = gf_mul(p2, a_i);
        p6    = gf_mul(p3, p3);
        p12   = gf_mul(p6, p6);
        p15   = gf_mul(p12, p3);
        p30   = gf_mul(p15, p15);
        p60   = gf_mul(p30, p30);
        p120  = gf_mul(p60, p60);
        p240  = gf_mul(p120, p120);
        p252  = gf_mul(p240, p12);
        inv_o = gf_mul(p252, p2);
    end

endmodule

// File: rtl/aes_subbytes_seq.sv
// Sequential SubBytes/InvSubBytes: captures a 128-bit state, substitutes LANES bytes per cycle,
// and presents the full result over a valid/ready handshake.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | din_ready high, waiting for an input handshake
//   ST_RUN   | one byte group substituted per cycle, g counts groups
//   ST_DRAIN | PIPE=1 only: last group written from the pipe register
//   ST_DONE  | result complete; dout_valid raised, held until dout_ready
module aes_subbytes_seq
    import aes_cfg::*;
#(
    parameter int LANES = 4,
    parameter int PIPE  = 0
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic [127:0] din,
    input  logic         dec,
    input  logic         din_valid,
    output logic         din_ready,
    output logic [127:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready
);

    localparam int NGROUPS = 16 / LANES;
    localparam int GW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam int LW      = LANES * 8;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("aes_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end
    if (!(PIPE == 0 || PIPE == 1)) begin : g_bad_pipe
        $error("aes_subbytes_seq: PIPE must be 0 or 1");
    end

    state_e         state_q, state_d;
    logic [GW-1:0]  g_q, g_d;
    logic [127:0]   blk_q, blk_d;
    logic           dec_q, dec_d;
    logic [127:0]   dout_q, dout_d;
    logic           dout_valid_q, dout_valid_d;
    logic           din_ready_q, din_ready_d;
    logic [LW-1:0]  pipe_q, pipe_d;
    logic [GW-1:0]  pipe_g_q, pipe_g_d;
    logic           pipe_v_q, pipe_v_d;

    logic [LW-1:0]  lane_x;
    logic [LW-1:0]  lane_y;
    logic           wr_en;
    logic [GW-1:0]  wr_g;
    logic [LW-1:0]  wr_data;
    logic           last_grp;

    always_comb begin
        lane_x = '0;
        for (int g = 0; g < NGROUPS; g++) begin
            if (g_q == GW'(g)) lane_x = blk_q[byte_lsb(g * LANES) +: LW];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        aes_sbox_byte u_sbox (
            .x   (lane_x[l*8 +: 8]),
            .dec (dec_q),
            .y   (lane_y[l*8 +: 8])
        );
    end

    // With PIPE the write port is fed from the pipe register one cycle behind the issue
    always_comb begin
        if (PIPE != 0) begin
            wr_en   = pipe_v_q;
            wr_g    = pipe_g_q;
            wr_data = pipe_q;
        end else begin
            wr_en   = (state_q == ST_RUN);
            wr_g    = g_q;
            wr_data = lane_y;
        end
        last_grp = (g_q == GW'(NGROUPS - 1));
    end

    always_comb begin
        state_d      = state_q;
        g_d          = g_q;
        blk_d        = blk_q;
        dec_d        = dec_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        din_ready_d  = din_ready_q;
        pipe_d       = pipe_q;
        pipe_g_d     = pipe_g_q;
        pipe_v_d     = 1'b0;

        if (wr_en) begin
            for (int g = 0; g < NGROUPS; g++) begin
                if (wr_g == GW'(g)) dout_d[byte_lsb(g * LANES) +: LW] = wr_data;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (din_valid && din_ready_q) begin
                    blk_d       = din;
                    dec_d       = dec;
                    g_d         = '0;
                    din_ready_d = 1'b0;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (PIPE != 0) begin
                    pipe_d   = lane_y;
                    pipe_g_d = g_q;
                    pipe_v_d = 1'b1;
                end
                if (last_grp) begin
                    g_d     = '0;
                    state_d = (PIPE != 0) ? ST_DRAIN : ST_DONE;
                end else begin
                    g_d = g_q + GW'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // dout_valid rises one edge after entry, giving the fixed N+PIPE+1 latency
                if (dout_valid_q && dout_ready) begin
                    dout_valid_d = 1'b0;
                    din_ready_d  = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    dout_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q      <= ST_IDLE;
            g_q          <= '0;
            blk_q        <= '0;
            dec_q        <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            din_ready_q  <= 1'b1;
            pipe_q       <= '0;
            pipe_g_q     <= '0;
            pipe_v_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            g_q          <= g_d;
            blk_q        <= blk_d;
            dec_q        <= dec_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            din_ready_q  <= din_ready_d;
            pipe_q       <= pipe_d;
            pipe_g_q     <= pipe_g_d;
            pipe_v_q     <= pipe_v_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign din_ready  = din_ready_q;

endmodule
